// File: rtl/reservation_unit_pkg.sv
// Shared state encoding, widths and reservation payload for the LR/SC reservation unit.
package reservation_unit_pkg;

    localparam int unsigned RSV_GRAN_MSB = 31;
    localparam int unsigned RSV_ADDR_W   = RSV_GRAN_MSB + 1;
    localparam int unsigned RSV_DATA_W   = 32;

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        RESERVED = 4'b0010,
        SC_CHECK = 4'b0100,
        SC_RESP  = 4'b1000
    } rsv_state_t;

    typedef struct packed {
        logic [RSV_ADDR_W-1:0] addr;
        logic [RSV_DATA_W-1:0] data;
    } rsv_entry_t;

endpackage

// File: rtl/reservation_unit_timer.sv
// Loadable down-counter that ages a reservation; saturates at zero.
module rsv_timer #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/reservation_unit.sv
// LR/SC reservation tracker with two-cycle SC verdict.
// Optional reservation ageing is compiled in with `define RESERVATION_TIMEOUT_EN.
module reservation_unit
    import reservation_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned GRAN_BITS      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  lr_i,
    input  logic                  sc_i,
    input  logic [RSV_ADDR_W-1:0] addr_i,
    input  logic [RSV_DATA_W-1:0] rdata_i,
    input  logic                  wr_i,
    input  logic [RSV_ADDR_W-1:0] wr_addr_i,
    output logic                  rsv_valid_o,
    output logic [RSV_ADDR_W-1:0] rsv_addr_o,
    output logic [RSV_DATA_W-1:0] rsv_data_o,
    output logic                  busy_o,
    output logic                  sc_done_o,
    output logic                  sc_fail_o
);

    rsv_state_t            state_q, state_d;
    rsv_entry_t            rsv_q, rsv_d;
    logic [RSV_ADDR_W-1:0] sc_addr_q, sc_addr_d;
    logic                  was_rsv_q, was_rsv_d;
    logic                  sc_conflict_q, sc_conflict_d;
    logic                  sc_fail_q, sc_fail_d;
    logic                  rsv_valid_q, busy_q, sc_done_q;
    logic                  wr_conflict_c, sc_match_c, timer_load_c, expired_c;
    logic                  gran_unused;

    // A store hits the reservation when it falls in the same granule.
    assign wr_conflict_c = wr_i &&
        (wr_addr_i[RSV_GRAN_MSB:GRAN_BITS] == rsv_q.addr[RSV_GRAN_MSB:GRAN_BITS]);

    assign sc_match_c = was_rsv_q && !sc_conflict_q && !wr_conflict_c &&
        (sc_addr_q[RSV_GRAN_MSB:GRAN_BITS] == rsv_q.addr[RSV_GRAN_MSB:GRAN_BITS]);

    assign gran_unused = ^{wr_addr_i[GRAN_BITS-1:0], sc_addr_q[GRAN_BITS-1:0]};

`ifdef RESERVATION_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] timer_cnt;

    rsv_timer #(
        .CNT_W(CNT_W)
    ) u_rsv_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (timer_load_c),
        .load_val_i (CNT_W'(TIMEOUT_CYCLES - 1)),
        .dec_i      (state_q == RESERVED),
        .count_o    (timer_cnt)
    );

    assign expired_c = (timer_cnt == '0);
`else
    logic timeout_unused;

    assign timeout_unused = ^{timer_load_c, TIMEOUT_CYCLES};
    assign expired_c      = 1'b0;
`endif

    // Next-state: an SC preempts everything, including a same-cycle LR.
    always_comb begin
        state_d       = state_q;
        rsv_d         = rsv_q;
        sc_addr_d     = sc_addr_q;
        was_rsv_d     = was_rsv_q;
        sc_conflict_d = sc_conflict_q;
        sc_fail_d     = sc_fail_q;
        timer_load_c  = 1'b0;

        if (sc_i) begin
            state_d       = SC_CHECK;
            sc_addr_d     = addr_i;
            was_rsv_d     = (state_q == RESERVED);
            sc_conflict_d = wr_conflict_c;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (lr_i) begin
                        state_d      = RESERVED;
                        rsv_d.addr   = addr_i;
                        rsv_d.data   = rdata_i;
                        timer_load_c = 1'b1;
                    end
                end
                RESERVED: begin
                    if (lr_i) begin
                        rsv_d.addr   = addr_i;
                        rsv_d.data   = rdata_i;
                        timer_load_c = 1'b1;
                    end else if (wr_conflict_c || expired_c) begin
                        state_d = IDLE;
                    end
                end
                SC_CHECK: begin
                    state_d   = SC_RESP;
                    sc_fail_d = !sc_match_c;
                end
                SC_RESP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Status flags are decoded from the next state so they leave a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rsv_q         <= '0;
            sc_addr_q     <= '0;
            was_rsv_q     <= 1'b0;
            sc_conflict_q <= 1'b0;
            sc_fail_q     <= 1'b0;
            rsv_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            sc_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rsv_q         <= rsv_d;
            sc_addr_q     <= sc_addr_d;
            was_rsv_q     <= was_rsv_d;
            sc_conflict_q <= sc_conflict_d;
            sc_fail_q     <= sc_fail_d;
            rsv_valid_q   <= (state_d == RESERVED);
            busy_q        <= (state_d == SC_CHECK) || (state_d == SC_RESP);
            sc_done_q     <= (state_d == SC_RESP);
        end
    end

    assign rsv_valid_o = rsv_valid_q;
    assign rsv_addr_o  = rsv_q.addr;
    assign rsv_data_o  = rsv_q.data;
    assign busy_o      = busy_q;
    assign sc_done_o   = sc_done_q;
    assign sc_fail_o   = sc_fail_q;

endmodule

// File: tb/tb_reservation_unit.sv
// Scoreboard bench for reservation_unit: directed scenarios plus random LR/SC/store traffic.
module tb_reservation_unit;

    localparam int unsigned TMO_CYC = 4;
    localparam int unsigned GRAN    = 2;
`ifdef RESERVATION_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        lr_i, sc_i, wr_i;
    logic [31:0] addr_i, rdata_i, wr_addr_i;
    logic        rsv_valid_o, busy_o, sc_done_o, sc_fail_o;
    logic [31:0] rsv_addr_o, rsv_data_o;

    reservation_unit #(
        .TIMEOUT_CYCLES (TMO_CYC),
        .GRAN_BITS      (GRAN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .lr_i        (lr_i),
        .sc_i        (sc_i),
        .addr_i      (addr_i),
        .rdata_i     (rdata_i),
        .wr_i        (wr_i),
        .wr_addr_i   (wr_addr_i),
        .rsv_valid_o (rsv_valid_o),
        .rsv_addr_o  (rsv_addr_o),
        .rsv_data_o  (rsv_data_o),
        .busy_o      (busy_o),
        .sc_done_o   (sc_done_o),
        .sc_fail_o   (sc_fail_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit fail;
        int due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    exp_t        new_e;

    // Reference model: the reservation as a plain record plus one in-flight SC.
    bit          m_valid;
    logic [31:0] m_addr, m_data;
    int          m_lr_edge;
    int          busy_left;
    bit          pend, pend_pass;
    bit          last_fail;
    bit          mon_en;
    int          done_cnt;
    int          d0;
    bit          lr_r, sc_r, w_r;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic bit same_gran(input logic [31:0] a, input logic [31:0] b);
        return (a >> GRAN) == (b >> GRAN);
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0:       return 32'h100;
            1:       return 32'h101;
            2:       return 32'h102;
            3:       return 32'h104;
            4:       return 32'h108;
            5:       return 32'h200;
            6:       return 32'h103;
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        m_valid   = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_lr_edge = 0;
        busy_left = 0;
        pend      = 1'b0;
        pend_pass = 1'b0;
        last_fail = 1'b0;
        exp_q.delete();
    endtask

    // Apply the rules for one clock edge using the inputs held across it.
    task automatic model_edge();
        int n;
        bit conflict;
        n        = cyc;
        conflict = wr_i && same_gran(wr_addr_i, m_addr);
        if (pend) begin
            pend_pass  = pend_pass && !conflict;
            new_e.fail = !pend_pass;
            new_e.due  = n + 1;
            exp_q.push_back(new_e);
            pend = 1'b0;
        end
        if (busy_left > 0) begin
            busy_left--;
        end else if (sc_i) begin
            pend      = 1'b1;
            pend_pass = m_valid && same_gran(addr_i, m_addr) && !conflict;
            m_valid   = 1'b0;
            busy_left = 2;
        end else if (lr_i) begin
            m_valid   = 1'b1;
            m_addr    = addr_i;
            m_data    = rdata_i;
            m_lr_edge = n;
        end else if (m_valid && conflict) begin
            m_valid = 1'b0;
        end else if (TMO_EN && m_valid && (n - m_lr_edge >= int'(TMO_CYC))) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input bit lr, input bit sc, input logic [31:0] a, input logic [31:0] d,
                        input bit w, input logic [31:0] wa);
        lr_i      = lr;
        sc_i      = sc;
        addr_i    = a;
        rdata_i   = d;
        wr_i      = w;
        wr_addr_i = wa;
        @(posedge clk);
        model_edge();
        #1;
        lr_i = 1'b0;
        sc_i = 1'b0;
        wr_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Monitor: pops an expected SC verdict whenever the DUT completes one.
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (sc_done_o) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sc_done_unexpected: got sc_done_o=1 expected none (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sc_fail", 32'(sc_fail_o), 32'(mon_e.fail));
                    check("sc_latency", cyc, mon_e.due);
                    last_fail = mon_e.fail;
                end
            end else begin
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    mon_e = exp_q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL sc_done_missing: got sc_done_o=0 expected 1 at cycle %0d", mon_e.due);
                end
                check("sc_fail_hold", 32'(sc_fail_o), 32'(last_fail));
            end
            check("rsv_valid", 32'(rsv_valid_o), 32'(m_valid));
            check("busy", 32'(busy_o), 32'(busy_left > 0));
            check("rsv_addr", rsv_addr_o, m_addr);
            check("rsv_data", rsv_data_o, m_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        lr_i      = 1'b0;
        sc_i      = 1'b0;
        wr_i      = 1'b0;
        addr_i    = '0;
        rdata_i   = '0;
        wr_addr_i = '0;
        mon_en    = 1'b0;
        done_cnt  = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsv_valid", 32'(rsv_valid_o), 32'h0);
        check("rst_rsv_addr", rsv_addr_o, 32'h0);
        check("rst_rsv_data", rsv_data_o, 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_sc_done", 32'(sc_done_o), 32'h0);
        check("rst_sc_fail", 32'(sc_fail_o), 32'h0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // LR then SC five cycles later to the same word.
        step(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0);
        idle(4);
        step(1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 32'h0);
        idle(1);
        check("s1_done", 32'(sc_done_o), 32'h1);
        check("s1_fail", 32'(sc_fail_o), 32'(TMO_EN));
        idle(1);
        check("s1_valid_after", 32'(rsv_valid_o), 32'h0);
        check("s1_done_once", 32'(sc_done_o), 32'h0);
        check("s1_data_hold", rsv_data_o, 32'hDEADBEEF);

        // Store to the same granule kills the reservation.
        step(1'b1, 1'b0, 32'h100, 32'h11111111, 1'b0, 32'h0);
        idle(1);
        check("s2_valid_before_wr", 32'(rsv_valid_o), 32'h1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h102);
        check("s2_valid_after_wr", 32'(rsv_valid_o), 32'h0);
        step(1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 32'h0);
        idle(2);
        check("s2_fail", 32'(sc_fail_o), 32'h1);

        // Store to another granule is harmless; SC to another granule fails.
        step(1'b1, 1'b0, 32'h100, 32'h22222222, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h104);
        check("s3_valid_other_wr", 32'(rsv_valid_o), 32'h1);
        step(1'b0, 1'b1, 32'h104, 32'h0, 1'b0, 32'h0);
        idle(2);
        check("s3_fail", 32'(sc_fail_o), 32'h1);

        // SC without reservation; LR+SC together leaves no new reservation.
        idle(1);
        step(1'b0, 1'b1, 32'h300, 32'h0, 1'b0, 32'h0);
        idle(2);
        check("s4_norsv_fail", 32'(sc_fail_o), 32'h1);
        step(1'b1, 1'b0, 32'h100, 32'h33333333, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h100, 32'h44444444, 1'b0, 32'h0);
        idle(2);
        check("s4_lrsc_fail", 32'(sc_fail_o), 32'h0);
        check("s4_lrsc_valid", 32'(rsv_valid_o), 32'h0);
        check("s4_lrsc_data", rsv_data_o, 32'h33333333);

`ifdef RESERVATION_TIMEOUT_EN
        // Ageing: SC three cycles after LR passes, six cycles after fails.
        step(1'b1, 1'b0, 32'h180, 32'h55555555, 1'b0, 32'h0);
        idle(2);
        step(1'b0, 1'b1, 32'h180, 32'h0, 1'b0, 32'h0);
        idle(2);
        check("s5_early_fail", 32'(sc_fail_o), 32'h0);
        step(1'b1, 1'b0, 32'h180, 32'h55555555, 1'b0, 32'h0);
        idle(5);
        step(1'b0, 1'b1, 32'h180, 32'h0, 1'b0, 32'h0);
        idle(2);
        check("s5_late_fail", 32'(sc_fail_o), 32'h1);
`endif

        // Reset while the SC is being checked drops it.
        step(1'b1, 1'b0, 32'h100, 32'h66666666, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 32'h0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("s6_rst_valid", 32'(rsv_valid_o), 32'h0);
        check("s6_rst_addr", rsv_addr_o, 32'h0);
        check("s6_rst_data", rsv_data_o, 32'h0);
        check("s6_rst_busy", 32'(busy_o), 32'h0);
        check("s6_rst_done", 32'(sc_done_o), 32'h0);
        check("s6_rst_fail", 32'(sc_fail_o), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        d0 = done_cnt;
        idle(5);
        check("s6_no_done", done_cnt, d0);

        // Random traffic; SCs are only issued while no SC is in flight.
        for (int i = 0; i < 3000; i++) begin
            lr_r = ($urandom_range(0, 3) == 0);
            sc_r = (busy_left == 0) && ($urandom_range(0, 6) == 0);
            w_r  = ($urandom_range(0, 4) == 0);
            step(lr_r, sc_r, pick_addr(), $urandom, w_r, pick_addr());
        end
        idle(4);
        check("queue_drained", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reservation_unit.md
RESERVATION_UNIT -- requirements
Module: reservation_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, cycles a reservation stays valid after an LR.
REQ-002 Parameter GRAN_BITS, default 2, low address bits ignored when matching a reservation (word granule).
REQ-003 Ports: clk in 1 core clock; reset_n in 1 asynchronous active-low reset; one clock only.
REQ-004 Ports: lr_i in 1 LR request pulse; sc_i in 1 SC request pulse; addr_i in 32 LR/SC address; rdata_i in 32 memory data returned for the LR.
REQ-005 Ports: wr_i in 1 any store committed to memory by another agent; wr_addr_i in 32 that store's address.
REQ-006 Ports: rsv_valid_o out 1 reservation held; rsv_addr_o out 32 reserved address; rsv_data_o out 32 data captured at LR.
REQ-007 Ports: busy_o out 1 SC in progress; sc_done_o out 1 one-cycle SC completion; sc_fail_o out 1 SC result, 1 = failed, valid with sc_done_o.

Function
REQ-008 FSM states: IDLE, RESERVED, SC_CHECK, SC_RESP.
REQ-009 IDLE: lr_i -> RESERVED next cycle; rsv_addr_o <= addr_i, rsv_data_o <= rdata_i, timeout counter <= TIMEOUT_CYCLES-1.
REQ-010 RESERVED: counter decrements by 1 per cycle and saturates at 0; rsv_valid_o = 1.
REQ-011 RESERVED with lr_i: re-arm. Address, data and counter are reloaded and the state stays RESERVED.
REQ-012 A conflicting store clears the reservation: wr_i with wr_addr_i[31:GRAN_BITS] == rsv_addr_o[31:GRAN_BITS] -> IDLE next cycle, rsv_valid_o = 0.
REQ-013 Counter expiry clears the reservation: counter == 0 in RESERVED -> IDLE next cycle.
REQ-014 sc_i in any state -> SC_CHECK next cycle; busy_o = 1 from the cycle after sc_i through SC_RESP.
REQ-015 SC_CHECK computes match = (state before SC was RESERVED) AND addr_i granule equals the reserved granule AND no conflicting store in the sc_i or SC_CHECK cycle.
REQ-016 addr_i is registered on sc_i; match uses the registered copy.
REQ-017 SC_RESP: sc_done_o = 1 for exactly one cycle with sc_fail_o = !match; the next state is IDLE.
REQ-018 SC latency: sc_done_o asserts exactly 2 cycles after the sc_i cycle.
REQ-019 The reservation is always cleared after any SC, whether it passes or fails.
REQ-020 lr_i and sc_i together in one cycle: sc_i wins and lr_i is ignored.
REQ-021 lr_i during SC_CHECK or SC_RESP is ignored.
REQ-022 wr_i and lr_i together in IDLE/RESERVED: the LR is captured and the wr_i compare uses the old address.
REQ-023 sc_fail_o holds its value between completions; rsv_addr_o and rsv_data_o hold their values after clear.

Reset
REQ-024 Asynchronous on negedge reset_n: state = IDLE, counter = 0, rsv_addr_o = 0, rsv_data_o = 0, captured SC address = 0.
REQ-025 Reset values of flags: rsv_valid_o = 0, busy_o = 0, sc_done_o = 0, sc_fail_o = 0.
REQ-026 Reset mid-SC drops the SC; no sc_done_o is produced for it.

Configuration
REQ-027 Macro RESERVATION_TIMEOUT_EN: when defined, the counter and REQ-010/REQ-013 are compiled in.
REQ-028 Without RESERVATION_TIMEOUT_EN: no counter logic exists, TIMEOUT_CYCLES is unused, and reservations clear only by store, SC or reset.

Structure
REQ-029 Shared package holds the rsv_state_t enum (one-hot, 4 bits) and the localparam RSV_GRAN_MSB = 31.
REQ-030 One sub-module, rsv_timer, holds the loadable down-counter; it is instantiated only under RESERVATION_TIMEOUT_EN.

Verification
REQ-031 Scenario: LR addr 0x100 with rdata 0xDEADBEEF, SC addr 0x100 after 5 cycles -> sc_done_o 2 cycles after sc_i, sc_fail_o = 0, rsv_valid_o = 0 after SC.
REQ-032 Scenario: LR 0x100, then wr_i at 0x102, then SC 0x100 -> sc_fail_o = 1; rsv_valid_o falls the cycle after wr_i.
REQ-033 Scenario: LR 0x100, SC 0x104 -> sc_fail_o = 1; also wr_i at 0x104 during RESERVED leaves rsv_valid_o = 1.
REQ-034 Scenario: RESERVATION_TIMEOUT_EN, TIMEOUT_CYCLES = 4, LR, SC at cycle 6 -> sc_fail_o = 1; SC at cycle 3 -> sc_fail_o = 0.
REQ-035 Scenario: SC with no prior LR -> sc_fail_o = 1; lr_i and sc_i together -> SC processed, no reservation afterwards.
REQ-036 Scenario: reset_n low during SC_CHECK -> all outputs 0 immediately and no sc_done_o afterwards.
